// File: rtl/uart_pkg.sv
// uart_pkg: register offsets and LSR bit positions shared by the UART.
// Imported by uart_fifo and uart_sync_fifo; no ports.
package uart_pkg;

   localparam logic [2:0] OFF_RBR_THR = 3'd0;
   localparam logic [2:0] OFF_IER     = 3'd1;
   localparam logic [2:0] OFF_LSR     = 3'd5;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO, WIDTH x DEPTH (DEPTH 2^n).
// Ports: clk_i, rst_ni (sync, active-low), push_i/data_i, pop_i,
//        head_o (current head), full_o, empty_o.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // A push into a full FIFO is legal when the head leaves this cycle.
   assign do_pop  = pop_i & !empty_o;
   assign do_push = push_i & (!full_o | do_pop);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: APB-style 16550-subset UART window with RX/TX FIFOs.
// Ports: APB-like bus (paddr, pdata, prdata, psel, penable, pwrite, pstb,
//        ready, perr), RX stream (rx_data/valid/ready), TX stream
//        (tx_data/valid/ready), irq. UART_IRQ_EN enables IER and irq.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h10000000,
   parameter int                    RX_DEPTH   = 8,
   parameter int                    TX_DEPTH   = 8
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pdata,
   output logic [DATA_WIDTH-1:0] prdata,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [3:0]            pstb,
   output logic                  ready,
   output logic                  perr,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  irq
);

   logic                  ready_q, ready_d;
   logic                  perr_q, perr_d;
   logic                  oe_q, oe_d, oe_clr;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [ADDR_WIDTH-1:0] off;
   logic [2:0]            reg_off;
   logic [1:0]            lane;
   logic                  acc, hit, stb;
   logic [7:0]            wbyte, rbyte, lsr;
   logic [1:0]            ier_rd;

   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] rx_head;

   assign acc     = psel & penable & !ready_q;
   assign off     = paddr - BASE_ADDR;
   assign hit     = (off < ADDR_WIDTH'(8));
   assign reg_off = off[2:0];
   assign lane    = paddr[1:0];
   assign stb     = pstb[lane];
   assign wbyte   = 8'(pdata >> {lane, 3'b000});

   assign rx_ready = !rx_full | rx_pop;
   assign rx_push  = rx_valid & rx_ready;
   assign tx_pop   = !tx_empty & tx_ready;
   assign tx_valid = !tx_empty;

   always_comb begin
      lsr           = 8'h00;
      lsr[LSR_DR]   = !rx_empty;
      lsr[LSR_OE]   = oe_q;
      lsr[LSR_THRE] = !tx_full;
      lsr[LSR_TEMT] = tx_empty;
   end

`ifdef UART_IRQ_EN
   logic [1:0] ier_q, ier_d;
   logic       irq_q;

   assign ier_rd = ier_q;
   assign irq    = irq_q;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         ier_q <= 2'b00;
         irq_q <= 1'b0;
      end else begin
         ier_q <= ier_d;
         irq_q <= (ier_q[0] & !rx_empty) | (ier_q[1] & tx_empty);
      end
   end
`else
   assign ier_rd = 2'b00;
   assign irq    = 1'b0;
`endif

   always_comb begin
      ready_d = acc;
      perr_d  = 1'b0;
      rbyte   = 8'h00;
      rx_pop  = 1'b0;
      tx_push = 1'b0;
      oe_clr  = 1'b0;
`ifdef UART_IRQ_EN
      ier_d   = ier_q;
`endif
      if (acc) begin
         if (!hit) begin
            perr_d = 1'b1;
         end else if (pwrite) begin
            unique case (1'b1)
               (reg_off == OFF_RBR_THR): begin
                  // Full is fine when the sink drains the head this edge.
                  if (stb) begin
                     if (!tx_full || tx_pop) tx_push = 1'b1;
                     else                    perr_d  = 1'b1;
                  end
               end
               (reg_off == OFF_IER): begin
`ifdef UART_IRQ_EN
                  if (stb) ier_d = wbyte[1:0];
`endif
               end
               (reg_off == OFF_LSR): perr_d = 1'b1;
               default: ;
            endcase
         end else begin
            unique case (1'b1)
               (reg_off == OFF_RBR_THR): begin
                  if (!rx_empty) begin
                     rbyte  = rx_head;
                     rx_pop = 1'b1;
                  end
               end
               (reg_off == OFF_IER): rbyte = {6'b0, ier_rd};
               (reg_off == OFF_LSR): begin
                  rbyte  = lsr;
                  oe_clr = 1'b1;
               end
               default: ;
            endcase
         end
      end
      prdata_d = DATA_WIDTH'(rbyte) << {lane, 3'b000};
   end

   // A new overrun in the same cycle as an LSR read must not be lost.
   assign oe_d = (oe_q & !oe_clr) | (rx_valid & !rx_ready);

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         ready_q  <= 1'b0;
         perr_q   <= 1'b0;
         oe_q     <= 1'b0;
         prdata_q <= '0;
      end else begin
         ready_q  <= ready_d;
         perr_q   <= perr_d;
         oe_q     <= oe_d;
         prdata_q <= prdata_d;
      end
   end

   assign ready  = ready_q;
   assign perr   = perr_q;
   assign prdata = prdata_q;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
      .clk_i   (pclk),
      .rst_ni  (presetn),
      .push_i  (rx_push),
      .data_i  (rx_data),
      .pop_i   (rx_pop),
      .head_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
      .clk_i   (pclk),
      .rst_ni  (presetn),
      .push_i  (tx_push),
      .data_i  (wbyte),
      .pop_i   (tx_pop),
      .head_o  (tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: randomized self-checking bench for uart_fifo.
// Reference model: byte queues for RX/TX plus a sticky overrun flag.
module tb_uart_fifo;

   localparam logic [31:0] BASE = 32'h10000000;
   localparam int          DEP  = 8;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [31:0] paddr, pdata, prdata;
   logic        psel, penable, pwrite;
   logic [3:0]  pstb;
   logic        ready, perr;
   logic [7:0]  rx_data, tx_data;
   logic        rx_valid, rx_ready, tx_valid, tx_ready, irq;

   int total = 0;
   int bad   = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic       oe_m;

   uart_fifo dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .paddr    (paddr),
      .pdata    (pdata),
      .prdata   (prdata),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pstb     (pstb),
      .ready    (ready),
      .perr     (perr),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .irq      (irq)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] lsr_m();
      return {1'b0, txq.size() == 0, txq.size() < DEP, 3'b000,
              oe_m, rxq.size() != 0};
   endfunction

   task automatic apb(input logic [31:0] a, input bit wr,
                      input logic [7:0] wb,
                      output logic [31:0] rd, output logic er);
      int n;
      @(negedge pclk);
      paddr   = a;
      pwrite  = wr;
      pdata   = 32'(wb) << (8 * a[1:0]);
      pstb    = 4'b0001 << a[1:0];
      psel    = 1'b1;
      penable = 1'b1;
      rd = '0;
      er = 1'b0;
      n  = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!ready && n < 10);
      if (ready) begin
         rd = prdata;
         er = perr;
      end else begin
         total++;
         bad++;
         $display("FAIL apb_timeout addr=%h", a);
      end
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        er;
      presetn  = 1'b0;
      psel     = 1'b0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pdata    = '0;
      pstb     = '0;
      rx_valid = 1'b0;
      rx_data  = '0;
      tx_ready = 1'b0;
      rxq.delete();
      txq.delete();
      oe_m = 1'b0;
      repeat (3) @(negedge pclk);
      total++;
      if ({ready, perr, prdata, tx_valid, rx_ready, irq} !==
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_state got rdy=%b err=%b prd=%h txv=%b rxr=%b irq=%b",
                  ready, perr, prdata, tx_valid, rx_ready, irq);
      end
      presetn = 1'b1;
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0000_6000 || er !== 1'b0) begin
         bad++;
         $display("FAIL reset_lsr got %h err=%b want 00006000 err=0", rd, er);
      end
      @(negedge pclk);
      total++;
      if (ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_pulse got %b want 0", ready);
      end
   endtask

   task automatic test_tx_order();
      logic [31:0] rd;
      logic        er;
      logic [7:0]  b [5];
      int          n;
      b[0] = 8'h41;
      b[1] = 8'h42;
      b[2] = 8'h43;
      b[3] = 8'($urandom);
      b[4] = 8'($urandom);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apb(BASE, 1'b1, b[i], rd, er);
         txq.push_back(b[i]);
         total++;
         if (er !== 1'b0) begin
            bad++;
            $display("FAIL thr_write_err i=%0d got %b want 0", i, er);
         end
      end
      @(negedge pclk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
         bad++;
         $display("FAIL tx_hold got v=%b d=%h want v=1 d=41", tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      n = 0;
      while (txq.size() > 0 && n < 50) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
            bad++;
            $display("FAIL tx_order got v=%b d=%h want %h", tx_valid, tx_data, txq[0]);
         end
         void'(txq.pop_front());
         @(negedge pclk);
         n++;
      end
      tx_ready = 1'b0;
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL tx_drained got v=%b want 0", tx_valid);
      end
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== {16'h0, lsr_m(), 8'h00} || rd[14] !== 1'b1) begin
         bad++;
         $display("FAIL tx_temt got %h want %h", rd, {16'h0, lsr_m(), 8'h00});
      end
   endtask

   task automatic test_rx_overrun();
      logic [31:0] rd;
      logic        er;
      logic        exp_r;
      for (int i = 0; i < 9; i++) begin
         @(negedge pclk);
         rx_data  = 8'($urandom);
         rx_valid = 1'b1;
         exp_r    = (rxq.size() < DEP);
         total++;
         if (rx_ready !== exp_r) begin
            bad++;
            $display("FAIL rx_ready i=%0d got %b want %b", i, rx_ready, exp_r);
         end
         if (exp_r) rxq.push_back(rx_data);
         else       oe_m = 1'b1;
      end
      @(negedge pclk);
      rx_valid = 1'b0;
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0000_6300 || rd !== {16'h0, lsr_m(), 8'h00}) begin
         bad++;
         $display("FAIL lsr_oe got %h want 00006300", rd);
      end
      oe_m = 1'b0;
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0000_6100) begin
         bad++;
         $display("FAIL lsr_oe_clr got %h want 00006100", rd);
      end
      for (int i = 0; i < DEP; i++) begin
         apb(BASE, 1'b0, 8'h00, rd, er);
         total++;
         if (rd !== 32'(rxq[0]) || er !== 1'b0) begin
            bad++;
            $display("FAIL rbr_data i=%0d got %h want %h", i, rd, rxq[0]);
         end
         void'(rxq.pop_front());
      end
      apb(BASE, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL rbr_empty got %h err=%b want 0", rd, er);
      end
   endtask

   task automatic test_tx_full();
      logic [31:0] rd;
      logic        er;
      logic [7:0]  b;
      int          n;
      tx_ready = 1'b0;
      for (int i = 0; i < DEP + 1; i++) begin
         b = 8'($urandom);
         apb(BASE, 1'b1, b, rd, er);
         total++;
         if (er !== (txq.size() == DEP)) begin
            bad++;
            $display("FAIL tx_full_err i=%0d got %b", i, er);
         end
         if (txq.size() < DEP) txq.push_back(b);
      end
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0) begin
         bad++;
         $display("FAIL lsr_full got %h want 0", rd);
      end
      b = 8'($urandom);
      @(negedge pclk);
      paddr   = BASE;
      pwrite  = 1'b1;
      pdata   = 32'(b);
      pstb    = 4'b0001;
      psel    = 1'b1;
      penable = 1'b1;
      tx_ready = 1'b1;
      total++;
      if (tx_data !== txq[0]) begin
         bad++;
         $display("FAIL tx_head got %h want %h", tx_data, txq[0]);
      end
      void'(txq.pop_front());
      @(negedge pclk);
      total++;
      if (ready !== 1'b1 || perr !== 1'b0) begin
         bad++;
         $display("FAIL push_pop_full got rdy=%b err=%b want 1 0", ready, perr);
      end
      psel = 1'b0;
      penable = 1'b0;
      pwrite = 1'b0;
      txq.push_back(b);
      n = 0;
      while (txq.size() > 0 && n < 50) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
            bad++;
            $display("FAIL tx_full_order got v=%b d=%h want %h", tx_valid, tx_data, txq[0]);
         end
         void'(txq.pop_front());
         @(negedge pclk);
         n++;
      end
      tx_ready = 1'b0;
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL tx_dropped got v=%b want 0", tx_valid);
      end
   endtask

   task automatic test_miss();
      logic [31:0] rd;
      logic        er;
      @(negedge pclk);
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      rxq.push_back(rx_data);
      @(negedge pclk);
      rx_valid = 1'b0;
      apb(32'h2000_0000, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         bad++;
         $display("FAIL miss_read got %h err=%b want 0 err=1", rd, er);
      end
      apb(BASE + 32'd8, 1'b1, 8'h5a, rd, er);
      total++;
      if (er !== 1'b1 || tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL miss_write got err=%b txv=%b want 1 0", er, tx_valid);
      end
      apb(BASE + 32'd5, 1'b1, 8'hff, rd, er);
      total++;
      if (er !== 1'b1) begin
         bad++;
         $display("FAIL lsr_write got err=%b want 1", er);
      end
      apb(BASE + 32'd7, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL off7 got %h err=%b want 0 0", rd, er);
      end
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== {16'h0, lsr_m(), 8'h00}) begin
         bad++;
         $display("FAIL miss_nochange got %h want %h", rd, {16'h0, lsr_m(), 8'h00});
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        er;
      logic        exp_rdy;
      for (int i = 0; i < 2; i++) begin
         @(negedge pclk);
         rx_data  = 8'($urandom);
         rx_valid = 1'b1;
         rxq.push_back(rx_data);
      end
      @(negedge pclk);
      rx_valid = 1'b0;
      paddr   = BASE;
      pwrite  = 1'b0;
      pstb    = 4'b0001;
      psel    = 1'b1;
      penable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge pclk);
         exp_rdy = (i % 2 == 0);
         total++;
         if (ready !== exp_rdy) begin
            bad++;
            $display("FAIL b2b_ready i=%0d got %b want %b", i, ready, exp_rdy);
         end
         if (exp_rdy && ready) begin
            total++;
            if (prdata !== 32'(rxq[0])) begin
               bad++;
               $display("FAIL b2b_data i=%0d got %h want %h", i, prdata, rxq[0]);
            end
            void'(rxq.pop_front());
         end
      end
      psel    = 1'b0;
      penable = 1'b0;
      apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== {16'h0, lsr_m(), 8'h00} || rd[8] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_pops got %h want %h", rd, {16'h0, lsr_m(), 8'h00});
      end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      logic        er;
`ifdef UART_IRQ_EN
      apb(BASE + 32'd1, 1'b1, 8'h01, rd, er);
      apb(BASE + 32'd1, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0000_0100 || er !== 1'b0) begin
         bad++;
         $display("FAIL ier_read got %h want 00000100", rd);
      end
      @(negedge pclk);
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      rxq.push_back(rx_data);
      @(negedge pclk);
      rx_valid = 1'b0;
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_early got %b want 0", irq);
      end
      @(negedge pclk);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_set got %b want 1", irq);
      end
      apb(BASE, 1'b0, 8'h00, rd, er);
      void'(rxq.pop_front());
      @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_clr got %b want 0", irq);
      end
      apb(BASE + 32'd1, 1'b1, 8'h00, rd, er);
`else
      apb(BASE + 32'd1, 1'b1, 8'h03, rd, er);
      apb(BASE + 32'd1, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL ier_raz got %h err=%b want 0 0", rd, er);
      end
      @(negedge pclk);
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      rxq.push_back(rx_data);
      @(negedge pclk);
      rx_valid = 1'b0;
      repeat (2) @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_tied got %b want 0", irq);
      end
      apb(BASE, 1'b0, 8'h00, rd, er);
      total++;
      if (rd !== 32'(rxq[0])) begin
         bad++;
         $display("FAIL irq_rbr got %h want %h", rd, rxq[0]);
      end
      void'(rxq.pop_front());
`endif
   endtask

   task automatic test_random();
      logic [31:0] rd;
      logic        er;
      logic [7:0]  b;
      logic [31:0] exp;
      logic        exp_r;
      for (int it = 0; it < 120; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               @(negedge pclk);
               rx_data  = 8'($urandom);
               rx_valid = 1'b1;
               exp_r    = (rxq.size() < DEP);
               total++;
               if (rx_ready !== exp_r) begin
                  bad++;
                  $display("FAIL rnd_rx_ready it=%0d got %b want %b", it, rx_ready, exp_r);
               end
               if (exp_r) rxq.push_back(rx_data);
               else       oe_m = 1'b1;
               @(negedge pclk);
               rx_valid = 1'b0;
            end
            1: begin
               b = 8'($urandom);
               apb(BASE, 1'b1, b, rd, er);
               exp_r = (txq.size() == DEP);
               total++;
               if (er !== exp_r) begin
                  bad++;
                  $display("FAIL rnd_thr it=%0d got %b want %b", it, er, exp_r);
               end
               if (!exp_r) txq.push_back(b);
            end
            2: begin
               apb(BASE, 1'b0, 8'h00, rd, er);
               exp = (rxq.size() > 0) ? 32'(rxq[0]) : 32'h0;
               if (rxq.size() > 0) void'(rxq.pop_front());
               total++;
               if (rd !== exp || er !== 1'b0) begin
                  bad++;
                  $display("FAIL rnd_rbr it=%0d got %h want %h", it, rd, exp);
               end
            end
            3: begin
               apb(BASE + 32'd5, 1'b0, 8'h00, rd, er);
               exp  = {16'h0, lsr_m(), 8'h00};
               oe_m = 1'b0;
               total++;
               if (rd !== exp || er !== 1'b0) begin
                  bad++;
                  $display("FAIL rnd_lsr it=%0d got %h want %h", it, rd, exp);
               end
            end
            default: begin
               @(negedge pclk);
               total++;
               if (tx_valid !== (txq.size() > 0) ||
                   (txq.size() > 0 && tx_data !== txq[0])) begin
                  bad++;
                  $display("FAIL rnd_tx it=%0d got v=%b d=%h", it, tx_valid, tx_data);
               end
               tx_ready = 1'b1;
               @(negedge pclk);
               tx_ready = 1'b0;
               if (txq.size() > 0) void'(txq.pop_front());
            end
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_tx_order();
      test_rx_overrun();
      test_tx_full();
      test_miss();
      test_back_to_back();
      test_irq();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
